// File: rtl/blinkled_pattern_player.sv
// rtl/blinkled_pattern_player.sv - Avalon-MM master that plays LED patterns from the data memory
module blinkled_pattern_player #(
    parameter int LED_WIDTH  = 10,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            ctl_address,
    input  logic                  ctl_chipselect,
    input  logic                  ctl_write,
    input  logic                  ctl_read,
    input  logic [31:0]           ctl_writedata,
    output logic [31:0]           ctl_readdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [3:0]            mem_byteenable,
    output logic                  mem_clken,
    input  logic [31:0]           mem_readdata,
    output logic [LED_WIDTH-1:0]  leds,
    output logic                  busy
);

    // Address sum is one bit wider than the memory address so the wrap compare sees the carry.
    localparam int SUM_W = ADDR_WIDTH + 1;
    localparam logic [SUM_W-1:0] DEPTH_W = SUM_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DWELL   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [15:0]           r_length;
    logic [31:0]           r_dwell;
    logic                  r_loop;
    logic                  r_done;
    logic [15:0]           r_idx;
    logic [31:0]           r_cnt;
    logic [LED_WIDTH-1:0]  r_leds;
    logic [31:0]           r_readdata;

    logic                  w_ctl_wr;
    logic                  w_wr_ctrl;
    logic                  w_run_req;
    logic                  w_stop_req;
    logic                  w_start;
    logic                  w_len_zero;
    logic                  w_last_word;
    logic                  w_dwell_end;
    logic                  w_busy;
    logic [SUM_W-1:0]      w_sum;

    assign w_ctl_wr    = ctl_chipselect & ctl_write;
    assign w_wr_ctrl   = w_ctl_wr && (ctl_address == 2'd0);
    assign w_run_req   = w_wr_ctrl && ctl_writedata[0];
    assign w_stop_req  = w_wr_ctrl && !ctl_writedata[0];
    assign w_busy      = (r_state != S_IDLE);
    assign w_start     = !w_busy && w_run_req;
    assign w_len_zero  = (r_length == 16'd0);
    assign w_last_word = (r_idx == r_length - 16'd1);
    assign w_dwell_end = (r_state == S_DWELL) && (r_cnt == 32'd0);

    assign w_sum       = SUM_W'(r_base) + SUM_W'(r_idx);
    assign mem_address = (w_sum >= DEPTH_W) ? ADDR_WIDTH'(w_sum - DEPTH_W) : ADDR_WIDTH'(w_sum);

    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;
    assign leds           = r_leds;
    assign ctl_readdata   = r_readdata;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a RUN=0 write overrides every transition out of a busy state.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_run_req && !w_len_zero) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH:   w_next_state = S_CAPTURE;
            S_CAPTURE: w_next_state = S_DWELL;
            S_DWELL: begin
                if (r_cnt == 32'd0) begin
                    if (!w_last_word || r_loop) begin
                        w_next_state = S_FETCH;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default:   w_next_state = S_IDLE;
        endcase
        if (w_busy && w_stop_req) begin
            w_next_state = S_IDLE;
        end
    end

    // State-decoded outputs: one read request per FETCH, busy outside IDLE.
    always_comb begin
        mem_chipselect = (r_state == S_FETCH);
        busy           = w_busy;
    end

    // Software-visible configuration; BASE and LENGTH are frozen while a pattern plays.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base   <= '0;
            r_length <= '0;
            r_dwell  <= '0;
            r_loop   <= 1'b0;
        end else if (w_ctl_wr) begin
            case (ctl_address)
                2'd0: r_loop <= ctl_writedata[1];
                2'd1: if (!w_busy) r_base <= ctl_writedata[ADDR_WIDTH-1:0];
                2'd2: if (!w_busy) r_length <= ctl_writedata[15:0];
                default: r_dwell <= ctl_writedata;
            endcase
        end
    end

    // Done flag: a start decides it first, then natural completion, then CLR_DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
        end else if (w_start) begin
            r_done <= w_len_zero;
        end else if (w_dwell_end && w_last_word && !r_loop && !w_stop_req) begin
            r_done <= 1'b1;
        end else if (w_wr_ctrl && ctl_writedata[2]) begin
            r_done <= 1'b0;
        end
    end

    // Word index and dwell counter; DWELL is sampled only when a word is captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start && !w_len_zero) begin
                        r_idx <= '0;
                    end
                end
                S_CAPTURE: begin
                    r_cnt <= (r_dwell == 32'd0) ? 32'd0 : r_dwell - 32'd1;
                end
                S_DWELL: begin
                    if (r_cnt != 32'd0) begin
                        r_cnt <= r_cnt - 32'd1;
                    end else if (!w_last_word) begin
                        r_idx <= r_idx + 16'd1;
                    end else begin
                        r_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // LED latch: loads the word returned for the preceding FETCH, otherwise holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_leds <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_leds <= mem_readdata[LED_WIDTH-1:0];
        end
    end

    // Registered control readback.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (ctl_chipselect && ctl_read) begin
            case (ctl_address)
                2'd0:    r_readdata <= {29'd0, r_loop, r_done, w_busy};
                2'd1:    r_readdata <= 32'(r_base);
                2'd2:    r_readdata <= 32'(r_length);
                default: r_readdata <= r_dwell;
            endcase
        end
    end

endmodule

// File: tb/tb_blinkled_pattern_player.sv
// tb/tb_blinkled_pattern_player.sv - scoreboard bench for blinkled_pattern_player
module tb_blinkled_pattern_player;

    localparam int LW    = 10;
    localparam int AW    = 16;
    localparam int DEPTH = 50000;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    ctl_address;
    logic          ctl_chipselect;
    logic          ctl_write;
    logic          ctl_read;
    logic [31:0]   ctl_writedata;
    logic [31:0]   ctl_readdata;
    logic [AW-1:0] mem_address;
    logic          mem_chipselect;
    logic          mem_write;
    logic [3:0]    mem_byteenable;
    logic          mem_clken;
    logic [31:0]   mem_readdata;
    logic [LW-1:0] leds;
    logic          busy;

    blinkled_pattern_player #(.LED_WIDTH(LW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .ctl_address    (ctl_address),
        .ctl_chipselect (ctl_chipselect),
        .ctl_write      (ctl_write),
        .ctl_read       (ctl_read),
        .ctl_writedata  (ctl_writedata),
        .ctl_readdata   (ctl_readdata),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .leds           (leds),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_model [0:DEPTH-1];

    always @(posedge clk) mem_readdata <= mem_model[mem_address];

    typedef struct {
        int          addr;
        logic [LW-1:0] led;
        int          gap;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int cycle = 0;
    int n_reads = 0;
    int last_cs = 0;
    int pend = 0;
    logic [LW-1:0] pend_led;
    exp_t mon_it;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every read request pops one expected word; leds are checked after capture.
    always @(negedge clk) begin
        if (pend > 0) begin
            pend--;
            if (pend == 0) check("leds_word", 32'(leds), 32'(pend_led));
        end
        if (mem_chipselect === 1'b1) begin
            n_reads++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_read actual_addr=%0d expected=no read", mem_address);
            end else begin
                mon_it = q.pop_front();
                check("mem_address", 32'(mem_address), 32'(mon_it.addr));
                if (mon_it.gap != 0) check("word_period", 32'(cycle - last_cs), 32'(mon_it.gap));
                pend = 2;
                pend_led = mon_it.led;
            end
            last_cs = cycle;
        end
    end

    task automatic push_item(input int a, input int gap);
        exp_t e;
        logic [31:0] w;
        w = mem_model[a];
        e.addr = a;
        e.led  = w[LW-1:0];
        e.gap  = gap;
        q.push_back(e);
    endtask

    // Reference: word k plays index k mod LENGTH at (BASE+index) mod DEPTH.
    task automatic model_run(input int base, input int len, input int dwell, input int n);
        for (int k = 0; k < n; k++) begin
            int a;
            a = (base + (k % len)) % DEPTH;
            push_item(a, (k == 0) ? 0 : (((dwell == 0) ? 1 : dwell) + 2));
        end
    endtask

    task automatic ctl_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        ctl_chipselect = 1'b1; ctl_write = 1'b1; ctl_address = a; ctl_writedata = d;
        @(posedge clk);
        #1;
        ctl_chipselect = 1'b0; ctl_write = 1'b0;
    endtask

    task automatic ctl_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        ctl_chipselect = 1'b1; ctl_read = 1'b1; ctl_address = a;
        @(posedge clk);
        #1;
        ctl_chipselect = 1'b0; ctl_read = 1'b0;
        d = ctl_readdata;
    endtask

    task automatic wait_reads(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (n_reads >= target) return;
        end
        total++; bad++;
        $display("FAIL wait_reads timeout actual=%0d expected=%0d", n_reads, target);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (busy === 1'b0) return;
        end
        total++; bad++;
        $display("FAIL wait_idle timeout actual_busy=%0b expected=0", busy);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] w;
        int r0, b, len, dw, lp, n;

        for (int i = 0; i < DEPTH; i++) mem_model[i] = $urandom;
        mem_model[100] = 32'h1;
        mem_model[101] = 32'h2;
        mem_model[102] = 32'h3;

        reset = 1'b1;
        ctl_address = 2'd0; ctl_chipselect = 1'b0; ctl_write = 1'b0; ctl_read = 1'b0;
        ctl_writedata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_leds", 32'(leds), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cs", 32'(mem_chipselect), 0);
        check("rst_readdata", ctl_readdata, 0);
        check("mem_write", 32'(mem_write), 0);
        check("mem_byteenable", 32'(mem_byteenable), 32'hF);
        check("mem_clken", 32'(mem_clken), 1);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            ctl_rd(2'(a), rd);
            check("rst_reg", rd, 0);
        end

        // Single pass over 100..102 with DWELL=4.
        ctl_wr(2'd1, 100); ctl_wr(2'd2, 3); ctl_wr(2'd3, 4);
        model_run(100, 3, 4, 3);
        r0 = n_reads;
        ctl_wr(2'd0, 32'h1);
        @(negedge clk);
        check("start_latency_cs", 32'(mem_chipselect), 1);
        wait_idle(500);
        ctl_rd(2'd0, rd);
        check("single_status", rd, 32'h2);
        check("single_reads", 32'(n_reads - r0), 3);
        check("single_last_led", 32'(leds), 3);

        // Loop with DWELL=0 for 20 periods of two words, then stop.
        ctl_wr(2'd1, 5); ctl_wr(2'd2, 2); ctl_wr(2'd3, 0);
        model_run(5, 2, 0, 40);
        r0 = n_reads;
        ctl_wr(2'd0, 32'h3);
        wait_reads(r0 + 40, 1000);
        ctl_wr(2'd0, 32'h0);
        @(negedge clk);
        check("loop_stop_busy", 32'(busy), 0);
        ctl_rd(2'd0, rd);
        check("loop_status", rd, 0);

        // Randomized runs.
        for (int t = 0; t < 5; t++) begin
            b   = $urandom_range(0, DEPTH - 1);
            len = $urandom_range(1, 6);
            dw  = $urandom_range(0, 5);
            lp  = $urandom_range(0, 1);
            n   = (lp != 0) ? len * 2 + 1 : len;
            ctl_wr(2'd1, b); ctl_wr(2'd2, len); ctl_wr(2'd3, dw);
            model_run(b, len, dw, n);
            r0 = n_reads;
            ctl_wr(2'd0, (lp != 0) ? 32'h3 : 32'h1);
            if (lp != 0) begin
                wait_reads(r0 + n, 2000);
                ctl_wr(2'd0, 32'h0);
                wait_idle(10);
                ctl_rd(2'd0, rd);
                check("rand_loop_status", rd, 0);
            end else begin
                wait_idle(2000);
                ctl_rd(2'd0, rd);
                check("rand_single_status", rd, 32'h2);
                check("rand_single_reads", 32'(n_reads - r0), 32'(len));
            end
        end

        // Address wrap at the top of memory.
        ctl_wr(2'd1, 49998); ctl_wr(2'd2, 4); ctl_wr(2'd3, 1);
        model_run(49998, 4, 1, 4);
        ctl_wr(2'd0, 32'h1);
        wait_idle(500);
        ctl_rd(2'd0, rd);
        check("wrap_status", rd, 32'h2);

        // CLR_DONE, then a start with LENGTH=0.
        ctl_wr(2'd0, 32'h4);
        ctl_rd(2'd0, rd);
        check("clr_done_status", rd, 0);
        ctl_wr(2'd2, 0);
        r0 = n_reads;
        ctl_wr(2'd0, 32'h1);
        @(negedge clk);
        check("len0_busy", 32'(busy), 0);
        ctl_rd(2'd0, rd);
        check("len0_status", rd, 32'h2);
        repeat (5) @(posedge clk);
        #2;
        check("len0_reads", 32'(n_reads - r0), 0);

        // Register writes while busy: BASE/LENGTH ignored, DWELL from next word.
        ctl_wr(2'd1, 200); ctl_wr(2'd2, 3); ctl_wr(2'd3, 6);
        model_run(200, 3, 6, 2);
        push_item(202, 4);
        r0 = n_reads;
        ctl_wr(2'd0, 32'h1);
        wait_reads(r0 + 1, 100);
        repeat (3) @(posedge clk);
        ctl_wr(2'd1, 7); ctl_wr(2'd2, 9); ctl_wr(2'd3, 2);
        ctl_rd(2'd1, rd);
        check("busy_base_readback", rd, 200);
        ctl_rd(2'd2, rd);
        check("busy_len_readback", rd, 3);
        wait_idle(500);
        ctl_rd(2'd0, rd);
        check("busy_status", rd, 32'h2);

        // Stop mid-dwell: leds hold, done stays 0.
        b = $urandom_range(0, DEPTH - 1);
        ctl_wr(2'd1, b); ctl_wr(2'd2, 3); ctl_wr(2'd3, 20);
        model_run(b, 3, 20, 1);
        r0 = n_reads;
        ctl_wr(2'd0, 32'h1);
        wait_reads(r0 + 1, 100);
        repeat (5) @(posedge clk);
        ctl_wr(2'd0, 32'h0);
        @(negedge clk);
        check("stop_busy", 32'(busy), 0);
        w = mem_model[b];
        check("stop_leds_hold", 32'(leds), 32'(w[LW-1:0]));
        ctl_rd(2'd0, rd);
        check("stop_status", rd, 0);
        repeat (5) @(posedge clk);
        #2;
        check("stop_leds_still", 32'(leds), 32'(w[LW-1:0]));

        // Reset in the middle of a looping pattern.
        b = $urandom_range(0, DEPTH - 1);
        ctl_wr(2'd1, b); ctl_wr(2'd2, 4); ctl_wr(2'd3, 20);
        model_run(b, 4, 20, 1);
        r0 = n_reads;
        ctl_wr(2'd0, 32'h3);
        wait_reads(r0 + 1, 100);
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_leds", 32'(leds), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_cs", 32'(mem_chipselect), 0);
        for (int a = 0; a < 4; a++) begin
            ctl_rd(2'(a), rd);
            check("midrst_reg", rd, 0);
        end
        repeat (30) @(posedge clk);
        #2;
        check("midrst_reads", 32'(n_reads - r0), 1);
        check("queue_empty", 32'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/blinkled_pattern_player.md
# blinkled_pattern_player

Avalon-MM master that plays LED patterns stored in the blinkled on-chip data memory. It reads a software-defined window of 32-bit words from that memory one at a time and drives the LED port from each word for a programmable number of clock cycles. It can stop after one pass or loop. It sits directly upstream of the data memory's s2 port, and software configures it through a small Avalon-MM control slave.

## Interface
Parameters:
- LED_WIDTH, 10, number of LED outputs; driven from `readdata[LED_WIDTH-1:0]`.
- ADDR_WIDTH, 16, data memory word-address width.
- DEPTH, 50000, data memory depth in words; used for address wrap.

Ports:
- clk  in  1  single clock. Same clock as the data memory.
- reset  in  1  synchronous, active-high reset.
- ctl_address  in  2  control register select.
- ctl_chipselect  in  1  control slave select.
- ctl_write  in  1  control write strobe; valid when chipselect is high.
- ctl_read  in  1  control read strobe; valid when chipselect is high.
- ctl_writedata  in  32  control write data.
- ctl_readdata  out  32  control read data, registered.
- mem_address  out  ADDR_WIDTH  word address to the data memory.
- mem_chipselect  out  1  memory read request.
- mem_write  out  1  tied to 0.
- mem_byteenable  out  4  tied to 4'hF.
- mem_clken  out  1  tied to 1.
- mem_readdata  in  32  memory read data. Valid one cycle after the address is presented.
- leds  out  LED_WIDTH  pattern output.
- busy  out  1  high while the FSM is not IDLE.

## Operation
Control registers (word offsets):
- 0: CTRL/STATUS.
  - Write: bit0 RUN, bit1 LOOP, bit2 CLR_DONE.
  - Read: bit0 busy, bit1 done, bit2 loop.
- 1: BASE, bits [ADDR_WIDTH-1:0], starting word address.
- 2: LENGTH, bits [15:0], number of words to play.
- 3: DWELL, bits [31:0], cycles each word is held. 0 is treated as 1.

Write rules:
- BASE and LENGTH writes are ignored while busy.
- A DWELL write takes effect at the next dwell load.
- LOOP is sampled on every CTRL write.

FSM states and transitions:
- IDLE:
  - Writing RUN=1 with LENGTH≠0 clears done, sets idx=0 and goes to FETCH.
  - Writing RUN=1 with LENGTH=0 sets done and stays in IDLE; no memory access occurs.
- FETCH: one cycle.
  - mem_chipselect=1.
  - mem_address = BASE+idx; if the sum ≥ DEPTH, use BASE+idx−DEPTH. The sum is computed at ADDR_WIDTH+1 bits.
  - Goes to CAPTURE.
- CAPTURE: one cycle.
  - leds ← mem_readdata[LED_WIDTH-1:0].
  - cnt ← max(DWELL,1)−1.
  - Goes to DWELL.
- DWELL: cnt decrements each cycle. When cnt=0:
  - If idx ≠ LENGTH−1: idx++ and go to FETCH.
  - Else if LOOP: idx=0 and go to FETCH.
  - Else: set done and go to IDLE.

Stop and hold behaviour:
- Writing RUN=0 in any non-IDLE state forces IDLE on the next edge. leds hold their last value and done stays 0.
- leds keep the last value in IDLE; they never clear except on reset.
- CLR_DONE clears done. If the same write also starts a run, the start wins (done ends up 0).

Reset values:
- state=IDLE; leds=0; busy=0; done=0; mem_chipselect=0.
- ctl_readdata=0; BASE=0; LENGTH=0; DWELL=0; LOOP=0; idx=0; cnt=0.

## Timing
- Control read: ctl_readdata is valid on the cycle after the ctl_read cycle (latency 1).
- Start latency: a CTRL write at edge T puts the block in FETCH during cycle T+1, with mem_chipselect high. The first leds update occurs at the edge ending cycle T+2.
- Word period: exactly max(DWELL,1)+2 cycles between successive leds updates, including across loop wrap.
- Memory accesses: mem_chipselect is high for exactly one cycle per word. mem_address is stable during that cycle.
- Simultaneous events:
  - A RUN=0 write arriving in the final DWELL cycle of the last word still results in done=0.
  - reset overrides every control write.
- Reset mid-operation: the block is in IDLE on the next cycle, leds=0, and no further memory reads are issued.

## Test plan
- Single-pass playback: memory holds 0x1,0x2,0x3 at 100..102. BASE=100, LENGTH=3, DWELL=4, RUN=1 → leds show 1,2,3 with updates 6 cycles apart, then done=1, busy=0, exactly 3 mem_chipselect pulses.
- Loop with DWELL=0: BASE=5, LENGTH=2, LOOP=1, DWELL=0 → leds alternate word5/word6 every 3 cycles for 20 periods. done stays 0.
- Address wrap: BASE=49998, LENGTH=4 → mem_address sequence 49998, 49999, 0, 1.
- LENGTH=0 start: RUN=1 → done=1 next cycle, mem_chipselect never asserts.
- Stop mid-dwell, then reset: RUN=0 written during DWELL → IDLE next cycle, leds hold, done=0. Then pulse reset during a running pattern → leds=0 and all registers zero next cycle.
- Register access while busy: write BASE while busy → readback unchanged. Write DWELL while busy → new period applies from the next word.
